// File: rtl/rv32_register_file.sv
// RV32 architectural integer register file: two combinational read ports and one write port.
// x0 reads as zero. A same-cycle write is forwarded to any read port that addresses it.
package rv32_isa;
  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;
endpackage

module rv32_register_file
  import rv32_isa::*;
#(
  parameter int NRegs = 32
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iWriteEn,
  input  logic [RegAddrWidth-1:0] iAddr_Rd,
  input  logic [RegAddrWidth-1:0] iAddr_Rs1,
  input  logic [RegAddrWidth-1:0] iAddr_Rs2,
  input  logic [RegWidth-1:0]     iRd,
  output logic [RegWidth-1:0]     oRs1,
  output logic [RegWidth-1:0]     oRs2
);

  // Entry 0 has no storage; entries 1..NRegs-1 are real flops.
  logic [NRegs-1:1][RegWidth-1:0] regs_q, regs_d;
  logic                           wr_valid;
  logic [RegWidth-1:0]            rs1_data, rs2_data;

  // Matching only indices 1..NRegs-1 excludes x0 and out-of-range addresses in one step.
  always_comb begin
    regs_d   = regs_q;
    wr_valid = 1'b0;
    for (int i = 1; i < NRegs; i++) begin
      if (iWriteEn && !iRst && (iAddr_Rd == RegAddrWidth'(i))) begin
        regs_d[i] = iRd;
        wr_valid  = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 1; i < NRegs; i++) begin
      if (iAddr_Rs1 == RegAddrWidth'(i)) rs1_data = regs_q[i];
      if (iAddr_Rs2 == RegAddrWidth'(i)) rs2_data = regs_q[i];
    end
    // Write-first bypass gives WB-to-ID forwarding without external logic.
    if (wr_valid && (iAddr_Rs1 == iAddr_Rd)) rs1_data = iRd;
    if (wr_valid && (iAddr_Rs2 == iAddr_Rd)) rs2_data = iRd;
  end

  assign oRs1 = rs1_data;
  assign oRs2 = rs2_data;

endmodule

// File: tb/tb_rv32_register_file.sv
// Directed bench for rv32_register_file: a full 32-entry instance and a 16-entry (RV32E)
// instance share one set of inputs, so every step checks both sizes against hand-computed values.
module tb_rv32_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addrRd, addrRs1, addrRs2;
  logic [31:0] rdData;
  logic [31:0] rs1Full, rs2Full, rs1Small, rs2Small;

  int errors = 0;
  int checks = 0;

  rv32_register_file #(.NRegs(32)) dut (
    .iClk(clk), .iRst(rst), .iWriteEn(we),
    .iAddr_Rd(addrRd), .iAddr_Rs1(addrRs1), .iAddr_Rs2(addrRs2),
    .iRd(rdData), .oRs1(rs1Full), .oRs2(rs2Full)
  );

  rv32_register_file #(.NRegs(16)) dut16 (
    .iClk(clk), .iRst(rst), .iWriteEn(we),
    .iAddr_Rd(addrRd), .iAddr_Rs1(addrRs1), .iAddr_Rs2(addrRs2),
    .iRd(rdData), .oRs1(rs1Small), .oRs2(rs2Small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic w, input logic [4:0] rd, input logic [31:0] d,
                               input logic [4:0] r1, input logic [4:0] r2);
    we      = w;
    addrRd  = rd;
    rdData  = d;
    addrRs1 = r1;
    addrRs2 = r2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] sweepValue(input int i, input int nRegs);
    if (i == 0 || i >= nRegs) return 32'h0;
    return 32'(i) * 32'h01010101;
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("in_reset_rs1", rs1Full, 32'h0);
    checkOutput("in_reset_rs2", rs2Full, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("after_reset_x5", rs1Full, 32'h0);

    // Write-enable gating
    applyStimulus(1'b0, 5'd3, 32'hCAFEBABE, 5'd3, 5'd3);
    #1;
    checkOutput("we0_no_bypass", rs1Full, 32'h0);
    @(posedge clk); #1;
    checkOutput("we0_x3_kept", rs1Full, 32'h0);
    checkOutput("we0_x3_kept_e", rs1Small, 32'h0);

    // Basic write/read on consecutive edges
    @(negedge clk);
    applyStimulus(1'b1, 5'd1, 32'h12345678, 5'd1, 5'd31);
    @(negedge clk);
    applyStimulus(1'b1, 5'd31, 32'hA5A5A5A5, 5'd1, 5'd31);
    #1;
    checkOutput("x31_bypass", rs2Full, 32'hA5A5A5A5);
    checkOutput("x31_oob_no_bypass_e", rs2Small, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    checkOutput("read_x1", rs1Full, 32'h12345678);
    checkOutput("read_x31", rs2Full, 32'hA5A5A5A5);
    checkOutput("read_x1_e", rs1Small, 32'h12345678);
    checkOutput("read_x31_oob_e", rs2Small, 32'h0);

    // x0 hardwire
    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    checkOutput("x0_during_write_rs1", rs1Full, 32'h0);
    checkOutput("x0_during_write_rs2", rs2Full, 32'h0);
    @(posedge clk); #1;
    checkOutput("x0_after_write_rs1", rs1Full, 32'h0);
    checkOutput("x0_after_write_rs2_e", rs2Small, 32'h0);

    // Bypass on both ports at once
    @(negedge clk);
    applyStimulus(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd7, 32'h22222222, 5'd7, 5'd7);
    #1;
    checkOutput("x7_stored", rs1Full, 32'h11111111);
    we = 1'b1;
    #1;
    checkOutput("bypass_rs1", rs1Full, 32'h22222222);
    checkOutput("bypass_rs2", rs2Full, 32'h22222222);
    checkOutput("bypass_rs2_e", rs2Small, 32'h22222222);
    @(negedge clk);
    we = 1'b0;
    #1;
    checkOutput("post_bypass_rs1", rs1Full, 32'h22222222);
    checkOutput("post_bypass_rs2", rs2Full, 32'h22222222);

    // Asynchronous reset between edges, writes blocked while held
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1);
    @(negedge clk);
    we = 1'b0;
    #1;
    checkOutput("x5_written", rs1Full, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_clear_x5", rs1Full, 32'h0);
    checkOutput("async_clear_x1", rs2Full, 32'h0);
    checkOutput("async_clear_x5_e", rs1Small, 32'h0);
    applyStimulus(1'b1, 5'd5, 32'h00000055, 5'd5, 5'd5);
    #1;
    checkOutput("reset_no_bypass", rs1Full, 32'h0);
    @(posedge clk); #1;
    checkOutput("reset_write_ignored", rs2Full, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    #1;
    checkOutput("post_reset_x5", rs1Full, 32'h0);

    // Sweep: xi <= i * 0x01010101, then read pairs (i, 31-i)
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    end
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addrRs1 = 5'(i);
      addrRs2 = 5'(31 - i);
      #1;
      checkOutput($sformatf("sweep_rs1_%0d", i), rs1Full, sweepValue(i, 32));
      checkOutput($sformatf("sweep_rs2_%0d", 31 - i), rs2Full, sweepValue(31 - i, 32));
      checkOutput($sformatf("sweep_e_rs1_%0d", i), rs1Small, sweepValue(i, 16));
      checkOutput($sformatf("sweep_e_rs2_%0d", 31 - i), rs2Small, sweepValue(31 - i, 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
